led_arbiter: RTL and testbench
==============================

Name: led_arbiter

Overview:
- Shares the board's 4 user LEDs between up to NUM_REQ internal requesters (status, debug, heartbeat, etc.) using round-robin arbitration.
- Time-slices each owner with a cycle quantum.
- Sits between the requester logic and the top-level LED driver; top-level inversion to n_led stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LED_W, 4, LED bus width
QUANTUM, 8, max cycles an owner holds the LEDs while another requester is pending (>=2)
BLINK_DIV, 24, toggle-period exponent for idle heartbeat (optional feature only)

Ports:
main_clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
req  input  NUM_REQ  per-requester request; held high while LEDs wanted
req_led  input  NUM_REQ*LED_W  requester i pattern at bits [i*LED_W +: LED_W]
grant  output  NUM_REQ  one-hot current owner, registered
led  output  LED_W  active-high LED value, registered
busy  output  1  high in GRANT state

Behaviour:
- All outputs are registered. Everything updates on posedge main_clk.
- rst low at a clock edge, with priority over everything including mid-grant:
  - state=IDLE, grant=0, led=0, busy=0, owner=0, ptr=0, cnt=0.
- State IDLE:
  - If req==0: stay in IDLE; led per optional feature.
  - Else: owner <= first index i with req[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - Same edge: grant <= onehot(owner), busy <= 1, cnt <= 0, state <= GRANT.
  - Latency: req sampled at edge N produces grant at edge N (visible cycle N+1).
- State GRANT:
  - led <= req_led slice of owner every cycle, so the pattern follows with 1 cycle latency.
  - cnt increments, saturating at QUANTUM-1.
  - If req[owner]==0: go to SWITCH.
  - Else if cnt==QUANTUM-1 and any other req bit is high: go to SWITCH (preempt).
  - Else: stay in GRANT. A sole requester keeps ownership indefinitely.
  - Release wins when release and preempt occur together; both give the same result.
- State SWITCH (exactly 1 cycle):
  - grant <= 0, led <= 0, busy <= 0.
  - ptr <= (owner+1) mod NUM_REQ.
  - state <= IDLE.
- Handoff timing: owner drops req at edge N -> grant=0 after N -> IDLE after N+1 -> new grant after N+2. This gives at least 2 blank cycles, so there is never overlap between owners.
- Fairness: ptr advances past the last owner. The wrap from index NUM_REQ-1 goes to 0.
- Constraints:
  - grant is never multi-hot.
  - led is 0 whenever grant==0, except under the optional feature.
  - req_led of non-owners is ignored.
- cnt width: clog2(QUANTUM). cnt never wraps.

Optional Feature:
- Macro LED_ARB_HEARTBEAT_EN.
- Defined:
  - A free-running BLINK_DIV-bit counter runs, cleared by reset.
  - In IDLE only, led[0] = counter MSB and the other led bits = 0.
  - In GRANT and SWITCH the heartbeat is not shown.
- Undefined:
  - No counter is present and led=0 in IDLE.
  - All other behaviour is identical.

Test Plan:
- Reset mid-grant: req=4'b0001, req_led0=4'hA, grant active; drive rst=0 one edge -> next cycle grant=0, led=0, busy=0, state IDLE. After release, grant=4'b0001 one cycle later.
- Single requester: req=4'b0100, req_led2=4'h5 held 50 cycles -> grant=4'b0100 the cycle after req; led=4'h5 one cycle later; no preemption; busy=1 throughout.
- Release handoff: req0 and req1 high, owner 0. Drop req0 at edge N -> grant=0 and led=0 after N, grant=4'b0010 after N+2.
- Quantum preemption: req=4'b1111 held constant with QUANTUM=8 -> grant sequence 0001, 0010, 0100, 1000, 0001. Each holds 8 cycles, separated by 2 zero-grant cycles.
- Wrap and fairness: owner 3 releases, req=4'b1001 -> next grant=4'b0001 (ptr wrapped to 0). Then with req=4'b0110 after ptr=1 -> grant=4'b0010.
- Heartbeat (LED_ARB_HEARTBEAT_EN, BLINK_DIV=4, req=0) -> led[0] toggles every 8 cycles, led[3:1]=0. Without the macro, led stays 0.

Source files
------------

// File: rtl/led_arbiter.sv
// ---------------------------------------------------------------------------
// led_arbiter : round-robin, time-sliced sharing of the user LEDs between
//               NUM_REQ requesters. Optional idle heartbeat: LED_ARB_HEARTBEAT_EN
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module led_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LED_W     = 4,
    parameter int QUANTUM   = 8,
    parameter int BLINK_DIV = 24
) (
    input  logic                     main_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] req_led,
    output logic [NUM_REQ-1:0]       grant,
    output logic [LED_W-1:0]         led,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QUANTUM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   IDX_WRAP = (IDX_W + 1)'(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("led_arbiter: NUM_REQ must be in 2..8");
        end
        if (QUANTUM < 2) begin : g_bad_quantum
            $error("led_arbiter: QUANTUM must be >= 2");
        end
        if (BLINK_DIV < 1) begin : g_bad_blink_div
            $error("led_arbiter: BLINK_DIV must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [LED_W-1:0]     led_nxt;
    logic                 busy_nxt;

    logic [LED_W-1:0]     slice [NUM_REQ];
    logic [LED_W-1:0]     owner_led;
    logic [LED_W-1:0]     led_idle;
    logic [IDX_W-1:0]     pick;
    logic                 pick_found;
    logic                 owner_req;
    logic                 others_req;
    logic [NUM_REQ-1:0]   owner_mask;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
            assign slice[i] = req_led[i*LED_W +: LED_W];
        end
    endgenerate

    assign owner_led  = slice[owner];
    assign owner_mask = NUM_REQ'(1) << owner;
    assign owner_req  = req[owner];
    assign others_req = |(req & ~owner_mask);

`ifdef LED_ARB_HEARTBEAT_EN
    logic [BLINK_DIV-1:0] hb_cnt;

    always_ff @(posedge main_clk) begin
        if (!rst) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_comb begin
        led_idle    = '0;
        led_idle[0] = hb_cnt[BLINK_DIV-1];
    end
`else
    assign led_idle = '0;
`endif

    // Round-robin search starting at ptr; wraps modulo NUM_REQ.
    always_comb begin
        logic [IDX_W:0] idx;
        idx        = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (idx >= IDX_WRAP) begin
                idx = idx - IDX_WRAP;
            end
            if (!pick_found && req[idx[IDX_W-1:0]]) begin
                pick       = idx[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        led_nxt   = led;
        busy_nxt  = busy;
        case (state)
            ST_IDLE: begin
                led_nxt = led_idle;
                if (pick_found) begin
                    owner_nxt = pick;
                    grant_nxt = NUM_REQ'(1) << pick;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                led_nxt = owner_led;
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
                // Release and quantum preemption share one exit path.
                if (!owner_req || (cnt == CNT_MAX && others_req)) begin
                    grant_nxt = '0;
                    led_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                ptr_nxt   = (owner == IDX_LAST) ? '0 : owner + 1'b1;
                grant_nxt = '0;
                led_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                grant_nxt = '0;
                led_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            grant <= '0;
            led   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            grant <= grant_nxt;
            led   <= led_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_arbiter : randomized bench for led_arbiter against a behavioural model
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int LED_W     = 4;
    localparam int QUANTUM   = 8;
    localparam int BLINK_DIV = 24;

    logic                     main_clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] req_led;
    logic [NUM_REQ-1:0]       grant;
    logic [LED_W-1:0]         led;
    logic                     busy;

    always #5 main_clk = ~main_clk;

    led_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LED_W    (LED_W),
        .QUANTUM  (QUANTUM),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .main_clk(main_clk),
        .rst     (rst),
        .req     (req),
        .req_led (req_led),
        .grant   (grant),
        .led     (led),
        .busy    (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = nobody), cycles held, one blank
    // cycle after each handoff, and the round-robin start point.
    int                   m_owner = -1;
    int                   m_held  = 0;
    bit                   m_gap   = 1'b0;
    int                   m_ptr   = 0;
    logic [BLINK_DIV-1:0] m_hb    = '0;
    logic [NUM_REQ-1:0]   e_grant = '0;
    logic [LED_W-1:0]     e_led   = '0;
    logic                 e_busy  = 1'b0;

    task automatic model_step();
        logic [LED_W-1:0] idle_led;
        bit               others;
        idle_led = '0;
`ifdef LED_ARB_HEARTBEAT_EN
        idle_led[0] = m_hb[BLINK_DIV-1];
`endif
        if (!rst) begin
            m_owner = -1; m_held = 0; m_gap = 1'b0; m_ptr = 0; m_hb = '0;
            e_grant = '0; e_led = '0; e_busy = 1'b0;
            return;
        end
        m_hb = m_hb + 1'b1;
        if (m_owner >= 0) begin
            others = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j != m_owner && req[j]) others = 1'b1;
            end
            if (!req[m_owner] || (m_held >= QUANTUM && others)) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
                m_gap   = 1'b1;
                e_grant = '0; e_led = '0; e_busy = 1'b0;
            end else begin
                e_led  = req_led[m_owner*LED_W +: LED_W];
                m_held = m_held + 1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            e_led = idle_led;
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (m_owner < 0 && req[j]) begin
                    m_owner = j;
                    m_held  = 1;
                    e_grant = NUM_REQ'(1) << j;
                    e_busy  = 1'b1;
                end
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs checked at the next one.
    task automatic run_cycle();
        model_step();
        @(posedge main_clk);
        @(negedge main_clk);
        check_val("grant", 32'(grant), 32'(e_grant));
        check_val("led", 32'(led), 32'(e_led));
        check_val("busy", 32'(busy), 32'(e_busy));
        check_val("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    int hold [NUM_REQ];

    initial begin
        rst     = 1'b0;
        req     = '0;
        req_led = '0;
        foreach (hold[i]) hold[i] = 0;
        @(negedge main_clk);

        for (int c = 0; c < 3; c++) run_cycle();
        rst = 1'b1;

        // Mid-grant reset with requester 0 holding pattern A.
        req = 4'b0001; req_led = 16'h000A;
        for (int c = 0; c < 6; c++) run_cycle();
        rst = 1'b0;
        run_cycle();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) run_cycle();

        // Sole requester: never preempted.
        req = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            req_led = 16'($urandom);
            run_cycle();
        end

        // All requesting: quantum rotation with wrap.
        req = 4'b1111;
        for (int c = 0; c < 90; c++) begin
            req_led = 16'($urandom);
            run_cycle();
        end

        // Randomized requests with persistence and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hold[i] == 0) begin
                    req[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 30);
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            req_led = 16'($urandom);
            rst     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            run_cycle();
        end

        rst = 1'b1;
        req = '0;
        for (int c = 0; c < 20; c++) begin
            req_led = 16'($urandom);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
